md5_search_scheduler: RTL and testbench

Parametrised search controller for the MD5 accelerator. It takes a candidate range and a 128-bit target digest and issues candidate bases to `LANES` parallel fixed-latency MD5 pipelines. It compares the returned digests against the target and reports the first match, per-lane hits, and run status. It sits between the top-level control/switch logic and the external MD5 pipeline array, and adds range, pause/resume, drain and stale-result rejection.

---
 rtl/md5_search_pkg.sv | 14 +
 rtl/md5_lane_compare.sv | 36 +++
 rtl/md5_search_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_md5_search_scheduler.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/md5_search_pkg.sv
// Shared constants and state encoding for the MD5 search scheduler.
package md5_search_pkg;
    localparam int DIGEST_W = 128;
    localparam int TAG_W    = 2;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_WARMING = 3'd1;
    localparam state_t ST_RUNNING = 3'd2;
    localparam state_t ST_PAUSED  = 3'd3;
    localparam state_t ST_DRAIN   = 3'd4;
    localparam state_t ST_DONE    = 3'd5;
endpackage

// File: rtl/md5_lane_compare.sv
// Combinational per-lane digest compare with range masking and a
// lowest-index-first priority encoder over the matching lanes.
module md5_lane_compare
    import md5_search_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int CAND_W = 32
) (
    input  logic [LANES*DIGEST_W-1:0] digest,
    input  logic [DIGEST_W-1:0]       target,
    input  logic [CAND_W-1:0]         base,
    input  logic [CAND_W-1:0]         range_end,
    output logic [LANES-1:0]          match,
    output logic [$clog2(LANES)-1:0]  first_lane,
    output logic                      any_match
);
    typedef logic [CAND_W:0] ext_t;

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            // Widened sum so a lane past 2^CAND_W-1 never aliases back into range.
            assign match[gi] = (digest[gi*DIGEST_W +: DIGEST_W] == target) &&
                               (({1'b0, base} + ext_t'(gi)) <= {1'b0, range_end});
        end
    endgenerate

    always_comb begin
        first_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (match[i]) first_lane = ($clog2(LANES))'(i);
        end
    end

    assign any_match = |match;
endmodule

// File: rtl/md5_search_scheduler.sv
// Search controller: issues candidate bases to LANES MD5 pipelines, filters
// returned results by run tag, and latches the first digest match of a run.
module md5_search_scheduler
    import md5_search_pkg::*;
#(
    parameter int LANES   = 4,
    parameter int CAND_W  = 32,
    parameter int LATENCY = 64
) (
    input  logic                      CLK,
    input  logic                      CPU_RESETN,
    input  logic                      start,
    input  logic                      enable,
    input  logic [CAND_W-1:0]         range_start,
    input  logic [CAND_W-1:0]         range_end,
    input  logic [DIGEST_W-1:0]       target_digest,
    output logic                      cand_valid,
    input  logic                      cand_ready,
    output logic [CAND_W-1:0]         cand_base,
    output logic [LANES-1:0]          cand_mask,
    output logic [TAG_W-1:0]          cand_tag,
    input  logic                      res_valid,
    input  logic [TAG_W-1:0]          res_tag,
    input  logic [CAND_W-1:0]         res_base,
    input  logic [LANES*DIGEST_W-1:0] res_digest,
    output logic                      status_warming,
    output logic                      status_running,
    output logic                      status_paused,
    output logic                      status_found,
    output logic                      status_done,
    output logic [CAND_W-1:0]         found_cand,
    output logic [$clog2(LANES)-1:0]  found_lane,
    output logic [LANES-1:0]          each_found
);
    localparam int CNT_W  = $clog2(LATENCY + 1);
    localparam int LANE_W = $clog2(LANES);
    typedef logic [CAND_W:0] ext_t;

    state_t              state_reg, state_next, prior_reg, prior_next;
    logic [TAG_W-1:0]    tag_reg, tag_next;
    ext_t                next_reg, next_next;
    logic [CAND_W-1:0]   end_reg, end_next;
    logic [DIGEST_W-1:0] target_reg, target_next;
    logic [CNT_W-1:0]    in_flight_reg, in_flight_next;
    logic                found_reg, found_next;
    logic [CAND_W-1:0]   found_cand_reg, found_cand_next;
    logic [LANE_W-1:0]   found_lane_reg, found_lane_next;
    logic [LANES-1:0]    each_found_reg, each_found_next;
    logic                cand_valid_reg, cand_valid_next;
    logic [LANES-1:0]    cand_mask_reg, issue_mask;
    logic [CAND_W-1:0]   cand_base_reg;
    logic [3:0]          status_reg, status_next;

    logic                hs, acc, stop, drained;
    logic [LANES-1:0]    match_vec;
    logic [LANE_W-1:0]   match_lane;
    logic                any_match;

    md5_lane_compare #(.LANES(LANES), .CAND_W(CAND_W)) u_compare (
        .digest     (res_digest),
        .target     (target_reg),
        .base       (res_base),
        .range_end  (end_reg),
        .match      (match_vec),
        .first_lane (match_lane),
        .any_match  (any_match)
    );

    always_comb begin
        state_next      = state_reg;
        prior_next      = prior_reg;
        tag_next        = tag_reg;
        next_next       = next_reg;
        end_next        = end_reg;
        target_next     = target_reg;
        in_flight_next  = in_flight_reg;
        found_next      = found_reg;
        found_cand_next = found_cand_reg;
        found_lane_next = found_lane_reg;
        each_found_next = each_found_reg;

        hs  = cand_valid_reg && cand_ready;
        acc = res_valid && (res_tag == tag_reg) &&
              (state_reg != ST_IDLE) && (state_reg != ST_DONE);

        if (hs) next_next = next_reg + ext_t'(LANES);
        if (hs && !acc)      in_flight_next = in_flight_reg + CNT_W'(1);
        else if (!hs && acc) in_flight_next = in_flight_reg - CNT_W'(1);

        if (acc) begin
            each_found_next = each_found_reg | match_vec;
            if (!found_reg && any_match) begin
                found_next      = 1'b1;
                found_cand_next = res_base + CAND_W'(match_lane);
                found_lane_next = match_lane;
            end
        end

        stop    = found_next || (next_next > {1'b0, end_reg});
        drained = (in_flight_next == '0);

        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    tag_next        = tag_reg + TAG_W'(1);
                    next_next       = {1'b0, range_start};
                    end_next        = range_end;
                    target_next     = target_digest;
                    in_flight_next  = '0;
                    found_next      = 1'b0;
                    found_cand_next = '0;
                    found_lane_next = '0;
                    each_found_next = '0;
                    prior_next      = ST_WARMING;
                    state_next      = (range_start > range_end) ? ST_DONE : ST_WARMING;
                end
            end
            ST_WARMING, ST_RUNNING: begin
                if (stop) begin
                    state_next = drained ? ST_DONE : ST_DRAIN;
                end else if (!enable) begin
                    state_next = ST_PAUSED;
                    prior_next = acc ? ST_RUNNING : state_reg;
                end else if (acc) begin
                    state_next = ST_RUNNING;
                end
            end
            ST_PAUSED: begin
                // Results keep flowing while paused, so warming can finish here.
                if (acc) prior_next = ST_RUNNING;
                if (stop)        state_next = drained ? ST_DONE : ST_DRAIN;
                else if (enable) state_next = prior_next;
            end
            ST_DRAIN: begin
                if (drained) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase

        cand_valid_next = ((state_next == ST_WARMING) || (state_next == ST_RUNNING)) && enable;
        status_next     = {state_next == ST_WARMING, state_next == ST_RUNNING,
                           state_next == ST_PAUSED,  state_next == ST_DONE};
    end

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_mask
            assign issue_mask[gi] = (next_next + ext_t'(gi)) <= {1'b0, end_next};
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!CPU_RESETN) begin
            state_reg      <= ST_IDLE;
            prior_reg      <= ST_IDLE;
            tag_reg        <= '0;
            next_reg       <= '0;
            end_reg        <= '0;
            target_reg     <= '0;
            in_flight_reg  <= '0;
            found_reg      <= 1'b0;
            found_cand_reg <= '0;
            found_lane_reg <= '0;
            each_found_reg <= '0;
            cand_valid_reg <= 1'b0;
            cand_base_reg  <= '0;
            cand_mask_reg  <= '0;
            status_reg     <= '0;
        end else begin
            state_reg      <= state_next;
            prior_reg      <= prior_next;
            tag_reg        <= tag_next;
            next_reg       <= next_next;
            end_reg        <= end_next;
            target_reg     <= target_next;
            in_flight_reg  <= in_flight_next;
            found_reg      <= found_next;
            found_cand_reg <= found_cand_next;
            found_lane_reg <= found_lane_next;
            each_found_reg <= each_found_next;
            cand_valid_reg <= cand_valid_next;
            cand_base_reg  <= next_next[CAND_W-1:0];
            cand_mask_reg  <= issue_mask;
            status_reg     <= status_next;
        end
    end

    assign cand_valid     = cand_valid_reg;
    assign cand_base      = cand_base_reg;
    assign cand_mask      = cand_mask_reg;
    assign cand_tag       = tag_reg;
    assign status_warming = status_reg[3];
    assign status_running = status_reg[2];
    assign status_paused  = status_reg[1];
    assign status_done    = status_reg[0];
    assign status_found   = found_reg;
    assign found_cand     = found_cand_reg;
    assign found_lane     = found_lane_reg;
    assign each_found     = each_found_reg;
endmodule

// File: tb/tb_md5_search_scheduler.sv
// Directed bench: a mock fixed-latency MD5 pipeline array feeds the scheduler.
module tb_md5_search_scheduler;
    localparam int LAT = 8;
    localparam logic [127:0] ALIAS = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;

    logic         CLK = 1'b0;
    logic         CPU_RESETN, start, enable, cand_ready, res_valid;
    logic [31:0]  range_start, range_end, res_base;
    logic [127:0] target_digest;
    logic [511:0] res_digest;
    logic [1:0]   res_tag, cand_tag, found_lane;
    logic         cand_valid, status_warming, status_running, status_paused, status_found, status_done;
    logic [31:0]  cand_base, found_cand;
    logic [3:0]   cand_mask, each_found;

    md5_search_scheduler #(.LANES(4), .CAND_W(32), .LATENCY(LAT)) dut (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .start(start), .enable(enable),
        .range_start(range_start), .range_end(range_end), .target_digest(target_digest),
        .cand_valid(cand_valid), .cand_ready(cand_ready), .cand_base(cand_base),
        .cand_mask(cand_mask), .cand_tag(cand_tag), .res_valid(res_valid),
        .res_tag(res_tag), .res_base(res_base), .res_digest(res_digest),
        .status_warming(status_warming), .status_running(status_running),
        .status_paused(status_paused), .status_found(status_found),
        .status_done(status_done), .found_cand(found_cand), .found_lane(found_lane),
        .each_found(each_found)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] base;
        logic [1:0]  tag;
        int          due;
        bit          stale;
    } ent_t;
    ent_t pq[$];

    int n_vec = 0, n_err = 0, cyc = 0;
    int n_issue, seq_err, found_issue, pause_issues, results;
    bit pause_window = 0;
    logic [31:0] exp_base, last_base;
    logic [3:0]  last_mask;

    // Candidate digests are injective, except 21 and 23 which share ALIAS.
    function automatic logic [127:0] dig(input logic [31:0] c);
        if (c == 32'd21 || c == 32'd23) return ALIAS;
        return {c ^ 32'h6745_2301, ~c, c * 32'h9E37_79B9, c + 32'h1234_5678};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bit hs_now;
        logic [31:0] b;
        logic [3:0]  m;
        logic [1:0]  t;
        ent_t e;
        hs_now = cand_valid && cand_ready;
        b = cand_base; m = cand_mask; t = cand_tag;
        if (hs_now && status_found) found_issue++;
        if (hs_now && pause_window) pause_issues++;
        if (res_valid) results++;
        @(posedge CLK); #1;
        cyc++;
        if (hs_now) begin
            n_issue++;
            last_base = b;
            last_mask = m;
            if (b != exp_base) seq_err++;
            exp_base = b + 32'd4;
            pq.push_back('{base: b, tag: t, due: cyc + LAT - 1, stale: 1'b0});
            $display("[%0d] issue base=%h mask=%b tag=%0d", cyc, b, m, t);
        end
        if (pq.size() > 0 && pq[0].due <= cyc) begin
            e = pq.pop_front();
            res_valid = 1'b1;
            res_base  = e.base;
            res_tag   = e.tag;
            for (int i = 0; i < 4; i++)
                res_digest[i*128 +: 128] = e.stale ? target_digest : dig(e.base + 32'(i));
            $display("[%0d] result base=%h tag=%0d stale=%0d", cyc, e.base, e.tag, e.stale);
        end else begin
            res_valid = 1'b0;
        end
    endtask

    task automatic do_start(input logic [31:0] s, input logic [31:0] e, input logic [127:0] tgt);
        range_start = s; range_end = e; target_digest = tgt;
        exp_base = s; n_issue = 0; seq_err = 0; found_issue = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!status_done && k < 500) begin
            tick();
            k++;
        end
        chk(tag, 128'(status_done), 128'd1);
    endtask

    initial begin
        int res_before;
        CPU_RESETN = 1'b0; start = 1'b0; enable = 1'b1; cand_ready = 1'b1;
        range_start = '0; range_end = '0; target_digest = '0;
        res_valid = 1'b0; res_tag = '0; res_base = '0; res_digest = '0;
        exp_base = '0; last_base = '0; last_mask = '0;
        n_issue = 0; seq_err = 0; found_issue = 0; pause_issues = 0; results = 0;
        repeat (3) tick();
        chk("reset_status", 128'({status_warming, status_running, status_paused, status_found, status_done}), 128'd0);
        chk("reset_issue", 128'({cand_valid, cand_base, cand_mask, cand_tag}), 128'd0);
        chk("reset_found", 128'({found_cand, found_lane, each_found}), 128'd0);
        CPU_RESETN = 1'b1;
        tick();

        // Range 0..99, single match on candidate 42
        do_start(32'd0, 32'd99, dig(32'd42));
        chk("t1_first_issue", 128'({cand_valid, cand_base, cand_mask, cand_tag}), 128'({1'b1, 32'd0, 4'hF, 2'd1}));
        chk("t1_warming", 128'(status_warming), 128'd1);
        wait_done("t1_done");
        chk("t1_found", 128'(status_found), 128'd1);
        chk("t1_found_cand", 128'(found_cand), 128'd42);
        chk("t1_found_lane", 128'(found_lane), 128'd2);
        chk("t1_each_found", 128'(each_found), 128'b0100);
        chk("t1_issue_after_found", 128'(found_issue), 128'd0);
        chk("t1_drained", 128'(pq.size()), 128'd0);

        // Range 0..9, no match: bases 0, 4, 8
        do_start(32'd0, 32'd9, dig(32'd1000));
        wait_done("t2_done");
        chk("t2_issues", 128'(n_issue), 128'd3);
        chk("t2_last_base", 128'(last_base), 128'd8);
        chk("t2_last_mask", 128'(last_mask), 128'b0011);
        chk("t2_found", 128'({status_found, each_found}), 128'd0);

        // Empty range finishes immediately
        do_start(32'd5, 32'd3, dig(32'd4));
        chk("empty_done", 128'({status_done, cand_valid, status_found}), 128'b100);

        // Pause for 20 cycles mid-run
        do_start(32'd0, 32'd199, dig(32'd5000));
        repeat (12) tick();
        chk("t3_running", 128'(status_running), 128'd1);
        enable = 1'b0;
        tick();
        chk("t3_paused", 128'({status_paused, cand_valid}), 128'b10);
        pause_window = 1'b1;
        res_before = results;
        repeat (19) tick();
        pause_window = 1'b0;
        chk("t3_no_issue_paused", 128'(pause_issues), 128'd0);
        chk("t3_results_paused", 128'(results > res_before), 128'd1);
        enable = 1'b1;
        wait_done("t3_done");
        chk("t3_sequence", 128'(seq_err), 128'd0);
        chk("t3_issues", 128'(n_issue), 128'd50);
        chk("t3_found", 128'(status_found), 128'd0);

        // Top of candidate space: one issue, no wrap
        do_start(32'hFFFF_FFFC, 32'hFFFF_FFFF, dig(32'd7));
        chk("t4_mask", 128'({cand_valid, cand_mask}), 128'b11111);
        tick();
        chk("t4_stop", 128'(cand_valid), 128'd0);
        wait_done("t4_done");
        chk("t4_issues", 128'(n_issue), 128'd1);

        // Reset mid-run, then stale results carrying foreign tags
        do_start(32'd0, 32'd99, dig(32'd60));
        repeat (5) tick();
        CPU_RESETN = 1'b0;
        pq.delete();
        repeat (2) tick();
        chk("t5_reset_out", 128'({cand_valid, cand_tag, status_warming, status_running, status_done}), 128'd0);
        CPU_RESETN = 1'b1;
        tick();
        do_start(32'd0, 32'd15, dig(32'd500));
        chk("t5_new_tag", 128'(cand_tag), 128'd1);
        pq.push_front('{base: 32'd0, tag: 2'd0, due: cyc, stale: 1'b1});
        pq.push_front('{base: 32'd4, tag: 2'd2, due: cyc, stale: 1'b1});
        pq.push_front('{base: 32'd8, tag: 2'd3, due: cyc, stale: 1'b1});
        wait_done("t5_done");
        chk("t5_no_found", 128'({status_found, each_found}), 128'd0);
        chk("t5_issues", 128'(n_issue), 128'd4);
        chk("t5_drained", 128'(pq.size()), 128'd0);

        // Lanes 1 and 3 of base 20 match together; a stray start is ignored
        do_start(32'd0, 32'd99, ALIAS);
        repeat (6) tick();
        range_start = 32'd50;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6_done");
        chk("t6_found_lane", 128'(found_lane), 128'd1);
        chk("t6_found_cand", 128'(found_cand), 128'd21);
        chk("t6_each_found", 128'(each_found), 128'b1010);
        chk("t6_sequence", 128'(seq_err), 128'd0);
        chk("t6_issue_after_found", 128'(found_issue), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
